// File: rtl/ff_ram_pkg.sv
// ff_ram_pkg
//   Shared types and sizing helpers for the flip-flop RAM with sequential
//   clear (ff_ram_sweep and its clear sequencer).
//   Contents:
//     ff_ram_state_t  - clear-sequencer FSM state {ST_IDLE, ST_CLEAR}
//     BYTE_W          - bits per byte lane
//     nbytes()        - number of byte lanes in a word (NBYTES = DW/8)
//     cnt_width()     - sweep counter width, clog2(DEPTH) with a 1-bit floor
package ff_ram_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } ff_ram_state_t;

  localparam int BYTE_W = 8;

  function automatic int nbytes(input int dw);
    return dw / BYTE_W;
  endfunction

  // DEPTH is at least 2, so clog2 is at least 1; the floor keeps the
  // vector width legal if someone ever passes a degenerate depth.
  function automatic int cnt_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/ff_ram_clr_seq.sv
// ff_ram_clr_seq
//   Clear sequencer: walks the array one word per clock, starting after
//   reset release or on a clear request seen while idle.
//   Ports:
//     clk       in   clock, rising edge
//     reset     in   asynchronous active-high reset; restarts the sweep at 0
//     clr_req   in   single-cycle clear request (only honoured in ST_IDLE)
//     busy      out  sweep in progress (registered)
//     clr_we    out  clear-write strobe for the array (registered)
//     clr_addr  out  word address being cleared this cycle
module ff_ram_clr_seq
  import ff_ram_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int CW    = cnt_width(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_req,
  output logic          busy,
  output logic          clr_we,
  output logic [CW-1:0] clr_addr
);

  // Terminal compare stops the counter before it could ever wrap.
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

  ff_ram_state_t r_state;
  logic [CW-1:0] r_cnt;
  logic          r_busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_CLEAR;
      r_cnt   <= '0;
      r_busy  <= 1'b1;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          // Requests during a sweep are ignored; the sweep is not restarted.
          if (r_cnt == LAST) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_IDLE: begin
          if (clr_req) begin
            r_state <= ST_CLEAR;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
          end
        end
        default: begin
          r_state <= ST_CLEAR;
          r_busy  <= 1'b1;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Every CLEAR cycle writes one word, so the strobe is the busy flop itself.
  assign busy     = r_busy;
  assign clr_we   = r_busy;
  assign clr_addr = r_cnt;

endmodule

// File: rtl/ff_ram_sweep.sv
// ff_ram_sweep
//   Parametrised flip-flop RAM with per-byte write enables, selectable
//   read-during-write behaviour and a one-word-per-cycle clear sweep.
//   Ports:
//     clk      in   clock, rising edge
//     reset    in   asynchronous active-high reset of control state and dout
//     clr_req  in   single-cycle request to start a clear sweep
//     wen      in   write strobe
//     wbe      in   byte enables, bit k covers din[8k+7:8k]
//     waddr    in   write address
//     din      in   write data
//     ren      in   read strobe
//     raddr    in   read address
//     dout     out  registered read data (1-cycle latency)
//     busy     out  clear sweep in progress
module ff_ram_sweep
  import ff_ram_pkg::*;
#(
  parameter int DW       = 32,
  parameter int AW       = 8,
  parameter int DEPTH    = 256,
  parameter int RDW_MODE = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clr_req,
  input  logic            wen,
  input  logic [DW/8-1:0] wbe,
  input  logic [AW-1:0]   waddr,
  input  logic [DW-1:0]   din,
  input  logic            ren,
  input  logic [AW-1:0]   raddr,
  output logic [DW-1:0]   dout,
  output logic            busy
);

  localparam int NBYTES = nbytes(DW);
  localparam int CW     = cnt_width(DEPTH);
  // One extra bit so DEPTH == 2^AW is representable in the range compare.
  localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);
  localparam bit BYPASS = (RDW_MODE == 1);

  // Array flops carry no reset; the sweep is what zeroes them.
  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_dout;

  logic          w_busy;
  logic          w_clr_we;
  logic [CW-1:0] w_clr_addr;
  logic          w_wr_in_range;
  logic          w_rd_in_range;
  logic          w_wr_ok;
  logic          w_bypass;
  logic [AW-1:0] w_waddr_idx;
  logic [AW-1:0] w_raddr_idx;
  logic [DW-1:0] w_wr_old;
  logic [DW-1:0] w_wr_word;
  logic [DW-1:0] w_rd_word;

  ff_ram_clr_seq #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_clr_seq (
    .clk      (clk),
    .reset    (reset),
    .clr_req  (clr_req),
    .busy     (w_busy),
    .clr_we   (w_clr_we),
    .clr_addr (w_clr_addr)
  );

  assign w_wr_in_range = ({1'b0, waddr} < DEPTH_L);
  assign w_rd_in_range = ({1'b0, raddr} < DEPTH_L);

  // Out-of-range addresses are steered to word 0 so the array is never
  // indexed past its end; the result is discarded by the range gates.
  assign w_waddr_idx = w_wr_in_range ? waddr : '0;
  assign w_raddr_idx = w_rd_in_range ? raddr : '0;

  // A clear request in the same cycle wins over the write.
  assign w_wr_ok = ~w_busy & wen & ~clr_req & w_wr_in_range;

  // Byte-enable merge: read-modify-write of the whole word keeps a single
  // write port on the array.
  assign w_wr_old = r_mem[w_waddr_idx];

  genvar gi;
  generate
    for (gi = 0; gi < NBYTES; gi++) begin : g_merge
      assign w_wr_word[BYTE_W*gi +: BYTE_W] =
        wbe[gi] ? din[BYTE_W*gi +: BYTE_W] : w_wr_old[BYTE_W*gi +: BYTE_W];
    end
  endgenerate

  // The merged word equals the post-write contents when the addresses match.
  assign w_bypass  = BYPASS && w_wr_ok && (waddr == raddr);
  assign w_rd_word = !w_rd_in_range ? '0 :
                     w_bypass       ? w_wr_word :
                                      r_mem[w_raddr_idx];

  // Clearing is held off while reset is asserted so the first clear write
  // lands on the first edge after release.
  always_ff @(posedge clk) begin
    if (w_clr_we && !reset) begin
      r_mem[w_clr_addr] <= '0;
    end else if (w_wr_ok) begin
      r_mem[w_waddr_idx] <= w_wr_word;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dout <= '0;
    end else if (ren) begin
      r_dout <= w_busy ? '0 : w_rd_word;
    end
  end

  assign dout = r_dout;
  assign busy = w_busy;

endmodule

// File: tb/tb_ff_ram_sweep.sv
module tb_ff_ram_sweep;

  localparam int D  = 256;
  localparam int D2 = 200;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus for the RDW_MODE 0 and RDW_MODE 1 instances.
  logic        rst = 1'b0, clr = 1'b0, wen = 1'b0, ren = 1'b0;
  logic [3:0]  wbe = '0;
  logic [7:0]  waddr = '0, raddr = '0;
  logic [31:0] din = '0;
  logic [31:0] dout0, dout1;
  logic        busy0, busy1;

  // Stimulus for the DEPTH = 200 instance.
  logic        b_rst = 1'b0, b_clr = 1'b0, b_wen = 1'b0, b_ren = 1'b0;
  logic [3:0]  b_wbe = '0;
  logic [7:0]  b_waddr = '0, b_raddr = '0;
  logic [31:0] b_din = '0;
  logic [31:0] b_dout;
  logic        b_busy;

  ff_ram_sweep #(.DW(32), .AW(8), .DEPTH(D), .RDW_MODE(0)) u_rdw0 (
    .clk(clk), .reset(rst), .clr_req(clr), .wen(wen), .wbe(wbe), .waddr(waddr),
    .din(din), .ren(ren), .raddr(raddr), .dout(dout0), .busy(busy0));

  ff_ram_sweep #(.DW(32), .AW(8), .DEPTH(D), .RDW_MODE(1)) u_rdw1 (
    .clk(clk), .reset(rst), .clr_req(clr), .wen(wen), .wbe(wbe), .waddr(waddr),
    .din(din), .ren(ren), .raddr(raddr), .dout(dout1), .busy(busy1));

  ff_ram_sweep #(.DW(32), .AW(8), .DEPTH(D2), .RDW_MODE(0)) u_d200 (
    .clk(clk), .reset(b_rst), .clr_req(b_clr), .wen(b_wen), .wbe(b_wbe),
    .waddr(b_waddr), .din(b_din), .ren(b_ren), .raddr(b_raddr),
    .dout(b_dout), .busy(b_busy));

  int n_vec = 0;
  int n_err = 0;

  // Reference model: memory contents, words still to be cleared, and the
  // read data each RDW flavour should present.
  logic [31:0] m_mem [D];
  int          m_left;
  logic [31:0] m_dout0, m_dout1;

  typedef struct {
    logic        w;
    logic [3:0]  be;
    logic [7:0]  wa;
    logic [31:0] d;
    logic        r;
    logic [7:0]  ra;
    logic [31:0] e0;
    logic [31:0] e1;
  } vec_t;

  vec_t tbl [12];

  function automatic logic [31:0] merge(input logic [31:0] old_w,
                                        input logic [31:0] new_w,
                                        input logic [3:0]  be);
    logic [31:0] res;
    res = old_w;
    for (int k = 0; k < 4; k++)
      if (be[k]) res[8*k +: 8] = new_w[8*k +: 8];
    return res;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model one rising edge using the inputs currently applied.
  task automatic model_edge();
    logic [31:0] old_w, new_w;
    logic        wr;
    if (m_left > 0) begin
      m_mem[D - m_left] = '0;
      if (ren) begin
        m_dout0 = '0;
        m_dout1 = '0;
      end
      m_left--;
    end else begin
      old_w = (int'(raddr) < D) ? m_mem[raddr] : '0;
      new_w = merge(m_mem[waddr], din, wbe);
      wr    = wen && !clr && (int'(waddr) < D);
      if (ren) begin
        m_dout0 = old_w;
        m_dout1 = (wr && waddr == raddr) ? new_w : old_w;
      end
      if (clr) m_left = D;
      else if (wr) m_mem[waddr] = new_w;
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic cycle(input logic c, input logic w, input logic [3:0] be,
                       input logic [7:0] wa, input logic [31:0] d,
                       input logic r, input logic [7:0] ra);
    clr = c; wen = w; wbe = be; waddr = wa; din = d; ren = r; raddr = ra;
    @(posedge clk);
    model_edge();
    #1;
    chk("busy0", {31'b0, busy0}, {31'b0, m_left > 0});
    chk("busy1", {31'b0, busy1}, {31'b0, m_left > 0});
    chk("dout0", dout0, m_dout0);
    chk("dout1", dout1, m_dout1);
    if (c || w || r)
      $display("t=%0t clr=%0b wen=%0b wbe=%h wa=%h din=%h ren=%0b ra=%h -> dout0=%h dout1=%h busy=%0b",
               $time, c, w, be, wa, d, r, ra, dout0, dout1, busy0);
    @(negedge clk);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 8'h00);
  endtask

  task automatic rd(input logic [7:0] ra);
    cycle(1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b1, ra);
  endtask

  task automatic apply_reset(input int hold);
    clr = 0; wen = 0; ren = 0;
    rst = 1'b1;
    #1;
    m_left  = D;
    m_dout0 = '0;
    m_dout1 = '0;
    chk("rst_busy", {31'b0, busy0}, 32'd1);
    chk("rst_dout0", dout0, 32'h0);
    chk("rst_dout1", dout1, 32'h0);
    $display("t=%0t reset asserted -> dout0=%h busy=%0b", $time, dout0, busy0);
    repeat (hold) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b0;
  endtask

  // Run idle cycles until busy drops; n0 edges of the sweep already elapsed.
  task automatic wait_idle(input string name, input int n0);
    int n;
    n = n0;
    while (busy0 && n < 2000) begin
      idle();
      n++;
    end
    chk(name, n, D);
    $display("t=%0t sweep %s lasted %0d edges", $time, name, n);
  endtask

  task automatic bcycle(input logic w, input logic [7:0] wa, input logic [31:0] d,
                        input logic r, input logic [7:0] ra);
    b_clr = 0; b_wen = w; b_wbe = 4'hF; b_waddr = wa; b_din = d; b_ren = r; b_raddr = ra;
    @(posedge clk);
    #1;
    if (w || r)
      $display("t=%0t d200 wen=%0b wa=%h din=%h ren=%0b ra=%h -> dout=%h busy=%0b",
               $time, w, wa, d, r, ra, b_dout, b_busy);
    @(negedge clk);
  endtask

  initial begin
    int n;
    logic c, w, r;
    logic [3:0] be;
    logic [7:0] wa, ra;
    logic [31:0] d;

    for (int i = 0; i < D; i++) m_mem[i] = '0;
    m_dout0 = '0;
    m_dout1 = '0;
    m_left  = D;

    tbl[0]  = '{1'b0, 4'h0, 8'd0,   32'h00000000, 1'b1, 8'd17,  32'h00000000, 32'h00000000};
    tbl[1]  = '{1'b1, 4'hF, 8'd5,   32'hFFFFFFFF, 1'b0, 8'd0,   32'h00000000, 32'h00000000};
    tbl[2]  = '{1'b1, 4'h5, 8'd5,   32'h12345678, 1'b1, 8'd5,   32'hFFFFFFFF, 32'hFF34FF78};
    tbl[3]  = '{1'b0, 4'h0, 8'd0,   32'h00000000, 1'b1, 8'd5,   32'hFF34FF78, 32'hFF34FF78};
    tbl[4]  = '{1'b1, 4'hF, 8'd9,   32'hAAAA5555, 1'b1, 8'd9,   32'h00000000, 32'hAAAA5555};
    tbl[5]  = '{1'b0, 4'h0, 8'd0,   32'h00000000, 1'b1, 8'd9,   32'hAAAA5555, 32'hAAAA5555};
    tbl[6]  = '{1'b1, 4'h0, 8'd3,   32'hDEADBEEF, 1'b1, 8'd3,   32'h00000000, 32'h00000000};
    tbl[7]  = '{1'b0, 4'h0, 8'd0,   32'h00000000, 1'b1, 8'd3,   32'h00000000, 32'h00000000};
    tbl[8]  = '{1'b1, 4'hF, 8'd255, 32'h11223344, 1'b1, 8'd255, 32'h00000000, 32'h11223344};
    tbl[9]  = '{1'b0, 4'h0, 8'd0,   32'h00000000, 1'b1, 8'd255, 32'h11223344, 32'h11223344};
    tbl[10] = '{1'b1, 4'h1, 8'd9,   32'h000000CC, 1'b1, 8'd5,   32'hFF34FF78, 32'hFF34FF78};
    tbl[11] = '{1'b0, 4'h0, 8'd0,   32'h00000000, 1'b1, 8'd9,   32'hAAAA55CC, 32'hAAAA55CC};

    @(negedge clk);
    b_rst = 1'b1;
    apply_reset(3);

    // Sweep after reset release, then reads of a cleared array.
    wait_idle("reset_sweep", 0);
    rd(8'd0);
    chk("post_rst_rd0", dout0, 32'h0);
    rd(8'd128);
    chk("post_rst_rd128", dout1, 32'h0);

    // Directed table.
    for (int i = 0; i < 12; i++) begin
      cycle(1'b0, tbl[i].w, tbl[i].be, tbl[i].wa, tbl[i].d, tbl[i].r, tbl[i].ra);
      chk($sformatf("tbl%0d_rdw0", i), dout0, tbl[i].e0);
      chk($sformatf("tbl%0d_rdw1", i), dout1, tbl[i].e1);
    end

    // Clear request with a colliding write and a pre-clear read.
    for (int i = 0; i < 4; i++)
      cycle(1'b0, 1'b1, 4'hF, 8'(i), 32'h100 + 32'(i), 1'b0, 8'd0);
    cycle(1'b1, 1'b1, 4'hF, 8'd2, 32'h77777777, 1'b1, 8'd1);
    chk("clr_preread", dout0, 32'h101);
    chk("clr_busy_rise", {31'b0, busy0}, 32'd1);
    wait_idle("clr_sweep", 0);
    for (int i = 0; i < 4; i++) begin
      rd(8'(i));
      chk($sformatf("clr_rd%0d", i), dout0, 32'h0);
    end

    // Reset in the middle of a sweep.
    cycle(1'b0, 1'b1, 4'hF, 8'd200, 32'h5A5A5A5A, 1'b0, 8'd0);
    cycle(1'b1, 1'b0, 4'h0, 8'd0, 32'h0, 1'b0, 8'd0);
    repeat (100) idle();
    apply_reset(2);
    cycle(1'b0, 1'b1, 4'hF, 8'd200, 32'h0000BEEF, 1'b1, 8'd200);
    wait_idle("midrst_sweep", 1);
    rd(8'd200);
    chk("midrst_rd200", dout0, 32'h0);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      c  = ($urandom_range(0, 199) == 0);
      w  = 1'($urandom_range(0, 1));
      r  = 1'($urandom_range(0, 1));
      be = 4'($urandom_range(0, 15));
      d  = $urandom;
      wa = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom_range(0, 7));
      ra = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom_range(0, 7));
      cycle(c, w, be, wa, d, r, ra);
    end

    // DEPTH = 200 instance: sweep length and out-of-range handling.
    chk("d200_rst_busy", {31'b0, b_busy}, 32'd1);
    chk("d200_rst_dout", b_dout, 32'h0);
    b_rst = 1'b0;
    n = 0;
    while (b_busy && n < 1000) begin
      bcycle(1'b0, 8'd0, 32'h0, 1'b0, 8'd0);
      n++;
    end
    chk("d200_sweep", n, D2);
    bcycle(1'b1, 8'd199, 32'hCAFEF00D, 1'b0, 8'd0);
    bcycle(1'b1, 8'd250, 32'h12345678, 1'b0, 8'd0);
    bcycle(1'b0, 8'd0, 32'h0, 1'b1, 8'd199);
    chk("d200_rd199", b_dout, 32'hCAFEF00D);
    bcycle(1'b0, 8'd0, 32'h0, 1'b1, 8'd250);
    chk("d200_rd250", b_dout, 32'h0);
    bcycle(1'b0, 8'd0, 32'h0, 1'b1, 8'd198);
    chk("d200_rd198", b_dout, 32'h0);
    bcycle(1'b0, 8'd0, 32'h0, 1'b1, 8'd244);
    chk("d200_rd244", b_dout, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ff_ram_sweep.md
# ff_ram_sweep

Parametrised flip-flop RAM for the subservient memory path, replacing the fixed 8-bit byte RAM. It adds configurable word width and depth, per-byte write enables, selectable read-during-write behaviour, and a sequential clear engine. The clear engine zeroes one word per cycle after reset or on request, instead of clearing the whole array in a single cycle. It sits between the CPU/debug bus adapter and the register-file/data-memory users.

## Interface
- `DW`, 32, data width in bits; must be a multiple of 8, ≥ 8
- `AW`, 8, address width
- `DEPTH`, 256, number of words; must satisfy 2 ≤ DEPTH ≤ 2^AW
- `RDW_MODE`, 0, read of the address being written in the same cycle: 0 = old data, 1 = new (byte-merged) data
- `clk`  in  1  clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-high reset of the control state and `dout` (not the array)
- `clr_req`  in  1  single-cycle request to start a clear sweep
- `wen`  in  1  write strobe
- `wbe`  in  DW/8  byte enables; bit k covers `din[8k+7:8k]`
- `waddr`  in  AW  write address
- `din`  in  DW  write data
- `ren`  in  1  read strobe
- `raddr`  in  AW  read address
- `dout`  out  DW  registered read data
- `busy`  out  1  clear sweep in progress

## Operation
- FSM states: CLEAR, IDLE. `reset` forces CLEAR with sweep counter = 0. `busy` = (state == CLEAR).
- CLEAR
  - Each clock: mem[cnt] ← 0, cnt ← cnt + 1.
  - When cnt == DEPTH−1 the final word is written and the state moves to IDLE on that edge.
  - `wen` is ignored.
  - `ren` loads `dout` ← 0.
  - `clr_req` is ignored; the sweep is not restarted.
- IDLE
  - `clr_req` = 1: go to CLEAR with cnt = 0. A `wen` in the same cycle is dropped. A `ren` in the same cycle is serviced normally with the pre-clear contents.
  - `wen` = 1 and waddr < DEPTH: each byte k with `wbe[k]` = 1 is written; the other bytes are kept. `wbe` = 0 writes nothing.
  - `wen` with waddr ≥ DEPTH: dropped silently.
  - `ren` = 1: `dout` ← mem[raddr], or 0 if raddr ≥ DEPTH.
  - `ren` = 0: `dout` holds its value.
- Read-during-write to the same address (IDLE):
  - RDW_MODE 0: `dout` gets the pre-write word.
  - RDW_MODE 1: `dout` gets the post-write word. Enabled bytes come from `din`; the rest from memory.
- Reset mid-sweep: the sweep restarts from address 0 after release. No partial-sweep state survives.
- Counter width: clog2(DEPTH) bits. Wrap never happens because of the DEPTH−1 terminal compare.

## Timing
- Reset values: `dout` = 0, `busy` = 1, state = CLEAR, cnt = 0.
- The first clear write is on the first rising edge after `reset` deasserts.
- `busy` stays high for exactly DEPTH edges after reset release, then is low.
- `clr_req` sampled high in IDLE: `busy` rises the following cycle and lasts DEPTH cycles.
- Read latency: 1 cycle. `dout` is valid the cycle after `ren` is sampled high.
- Write latency: 1 cycle. A read issued the cycle after a write returns the new data in both modes.
- `dout` and `busy` are driven directly from flops. No combinational path runs from inputs to outputs.

## Structure
- Package `ff_ram_pkg` holds:
  - the state typedef `ff_ram_state_t` {ST_IDLE, ST_CLEAR}
  - the byte-count helper `NBYTES = DW/8`
  - the clog2-based counter-width function
- Sub-module `ff_ram_clr_seq` holds the FSM, sweep counter and `busy`. It outputs the clear-write strobe and clear address.
- The top level holds:
  - the array, with no reset on the array flops
  - the byte-enable merge
  - the read mux with RDW_MODE bypass and out-of-range gating
  - the `dout` register

## Test plan
- Reset release with DEPTH = 256: `busy` is high for 256 cycles, then low. A read of any address then returns 0x00000000.
- Pre-fill addr 5 with 0xFFFFFFFF, then write 0x12345678 with `wbe` = 4'b0101. The next-cycle read of addr 5 returns 0xFF34FF78.
- Same-cycle write 0xAAAA5555 and read at addr 9, whose old value is 0x0: RDW_MODE 0 gives `dout` = 0x0; RDW_MODE 1 gives `dout` = 0xAAAA5555.
- In IDLE, fill addrs 0–3, then pulse `clr_req` together with `wen`:
  - `busy` rises next cycle;
  - the write is dropped;
  - after DEPTH cycles all reads return 0.
- Assert `reset` at cycle 100 of a sweep, release it, and write addr 200 during `busy`: the write is ignored, `busy` lasts a full DEPTH cycles, and addr 200 reads 0.
- With DEPTH = 200 and AW = 8: a write to addr 250 is dropped and a read of addr 250 returns 0. A read of addr 199 after writing it returns the written value.
